tape_player: RTL and testbench



---
 rtl/tape_pkg.sv | 17 +
 rtl/tape_serializer.sv | 100 ++++++++++
 rtl/tape_player.sv | 195 +++++++++++++++++++
 tb/tb_tape_player.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the tape-input player.
//   state_t     : sequencing states of tape_player
//   SYNC_BYTE   : byte sent between leader and data
//   LEADER_BYTE : byte repeated during the leader
package tape_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SYNC,
        DATA
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hE6;
    localparam logic [7:0] LEADER_BYTE = 8'h00;

endpackage

// File: rtl/tape_serializer.sv
// Biphase serializer: shifts one byte out MSB first, each bit as two
// half-periods (~bit, then bit), each lasting HALF_PERIOD ce ticks.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clear_i         : synchronous abort, same effect as reset
//   ce_i            : timing tick
//   load_valid_i    : load_byte_i is offered
//   load_byte_i     : byte to send
//   load_ready_o    : a byte is accepted this cycle if offered
//   tapein_o        : biphase output (holds its level while starved)
//   byte_done_o     : strobe in the cycle the last half-bit ends
module tape_serializer #(
    parameter int unsigned HALF_PERIOD = 741
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       ce_i,
    input  logic       load_valid_i,
    input  logic [7:0] load_byte_i,
    output logic       load_ready_o,
    output logic       tapein_o,
    output logic       byte_done_o
);

    localparam int unsigned TW = $clog2(HALF_PERIOD + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(HALF_PERIOD - 1);

    logic          active_q, active_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic          half_q, half_d;
    logic [7:0]    sh_q, sh_d;
    logic          tapein_q, tapein_d;

    logic half_end;
    logic byte_end;
    logic load;

    assign half_end     = active_q && ce_i && (tick_q == TICK_LAST);
    assign byte_end     = half_end && half_q && (bit_q == 3'd0);
    // Ready at the closing tick too, so back-to-back bytes carry no gap.
    assign load_ready_o = !active_q || byte_end;
    assign load         = load_ready_o && load_valid_i;
    assign byte_done_o  = byte_end;
    assign tapein_o     = tapein_q;

    always_comb begin
        active_d = active_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        half_d   = half_q;
        sh_d     = sh_q;
        tapein_d = tapein_q;
        if (load) begin
            active_d = 1'b1;
            sh_d     = load_byte_i;
            bit_d    = 3'd7;
            half_d   = 1'b0;
            tick_d   = '0;
            tapein_d = ~load_byte_i[7];
        end else if (byte_end) begin
            // Starved: tick count stops and the line keeps its last level.
            active_d = 1'b0;
            tick_d   = '0;
        end else if (half_end) begin
            tick_d = '0;
            if (!half_q) begin
                half_d   = 1'b1;
                tapein_d = sh_q[7];
            end else begin
                half_d   = 1'b0;
                bit_d    = bit_q - 1'b1;
                sh_d     = {sh_q[6:0], 1'b0};
                tapein_d = ~sh_q[6];
            end
        end else if (active_q && ce_i) begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            half_q   <= 1'b0;
            sh_q     <= '0;
            tapein_q <= 1'b0;
        end else begin
            active_q <= active_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            sh_q     <= sh_d;
            tapein_q <= tapein_d;
        end
    end

endmodule

// File: rtl/tape_player.sv
// Tape-in source: plays a leader of LEADER_BYTE, SYNC_BYTE, then `length`
// bytes fetched from memory, as a biphase signal for the monitor loader.
// Ports:
//   clk_sys, reset       : clock, synchronous active-high reset
//   ce                   : timing tick
//   start / stop         : one-cycle pulses; stop has priority
//   length               : data byte count, sampled on start
//   rd_req/rd_addr       : byte fetch request, held until rd_ack
//   rd_data/rd_ack       : fetched byte, valid in the one-cycle ack
//   tapein               : biphase output, 0 when idle
//   busy / done          : playback active / normal completion strobe
//   underrun             : sticky, set when a data byte was not ready
module tape_player
    import tape_pkg::*;
#(
    parameter int unsigned HALF_PERIOD  = 741,
    parameter int unsigned LEADER_BYTES = 256,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] length,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              rd_ack,
    output logic              tapein,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int unsigned LW = $clog2(LEADER_BYTES + 1);
    localparam logic [LW-1:0] LEAD_LAST = LW'(LEADER_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] length_q, length_d;
    logic [ADDR_W-1:0] sent_q, sent_d;
    logic [LW-1:0]     lead_q, lead_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;

    logic       ser_valid;
    logic [7:0] ser_byte;
    logic       ser_ready;
    logic       ser_done;
    logic       ser_tapein;
    logic       take_buf;
    logic       finish;

    tape_serializer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_ser (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .clear_i     (stop),
        .ce_i        (ce),
        .load_valid_i(ser_valid),
        .load_byte_i (ser_byte),
        .load_ready_o(ser_ready),
        .tapein_o    (ser_tapein),
        .byte_done_o (ser_done)
    );

    // lead_q counts leader bytes already handed to the serializer, so the
    // byte offered at each boundary is chosen from the current count.
    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        sent_d      = sent_q;
        lead_d      = lead_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        ser_valid   = 1'b0;
        ser_byte    = LEADER_BYTE;
        take_buf    = 1'b0;
        finish      = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            rd_req_d    = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            if (rd_req_q && rd_ack) begin
                rd_req_d    = 1'b0;
                rd_addr_d   = rd_addr_q + 1'b1;
                buf_d       = rd_data;
                buf_valid_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        ser_valid   = 1'b1;
                        length_d    = length;
                        rd_addr_d   = '0;
                        underrun_d  = 1'b0;
                        lead_d      = LW'(1);
                        sent_d      = '0;
                        rd_req_d    = 1'b1;
                        buf_valid_d = 1'b0;
                        state_d     = LEAD;
                    end
                end
                LEAD: begin
                    ser_valid = 1'b1;
                    if (lead_q == LEAD_LAST) ser_byte = SYNC_BYTE;
                    if (ser_done) begin
                        if (lead_q == LEAD_LAST) state_d = SYNC;
                        else                     lead_d  = lead_q + 1'b1;
                    end
                end
                SYNC: begin
                    if (ser_done) begin
                        if (length_q == '0) begin
                            finish = 1'b1;
                        end else begin
                            state_d  = DATA;
                            take_buf = buf_valid_q;
                        end
                    end
                end
                DATA: begin
                    if (ser_done && (sent_q == length_q)) begin
                        finish = 1'b1;
                    end else if (ser_ready) begin
                        if (buf_valid_q) take_buf   = 1'b1;
                        else             underrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (take_buf) begin
                ser_valid   = 1'b1;
                ser_byte    = buf_q;
                buf_valid_d = 1'b0;
                sent_d      = sent_q + 1'b1;
                if (rd_addr_q < length_q) rd_req_d = 1'b1;
            end

            if (finish) begin
                state_d     = IDLE;
                done_d      = 1'b1;
                rd_req_d    = 1'b0;
                buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            length_q    <= '0;
            sent_q      <= '0;
            lead_q      <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            sent_q      <= sent_d;
            lead_q      <= lead_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign tapein   = ser_tapein && busy;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_tape_player.sv
module tb_tape_player;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce      = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic [15:0] length  = '0;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_ack;
    logic        tapein;
    logic        busy;
    logic        done;
    logic        underrun;

    tape_player #(
        .HALF_PERIOD (4),
        .LEADER_BYTES(2),
        .ADDR_W      (16)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .start   (start),
        .stop    (stop),
        .length  (length),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_ack  (rd_ack),
        .tapein  (tapein),
        .busy    (busy),
        .done    (done),
        .underrun(underrun)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    logic wave [0:8191];
    int busy_cnt, done_cnt, done_cyc, req_rises;
    logic prev_req = 1'b0;

    logic [7:0] mem [0:1];
    int   slow_addr  = -1;
    int   slow_delay = 3;
    logic mem_en     = 1'b1;
    logic force_ack  = 1'b0;
    int   ack_edge [0:1];
    int   wait_cnt   = 0;

    logic [7:0] exp_q [$];
    int e0;

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    // Observation: waveform log indexed by the number of posedges seen.
    initial forever begin
        @(negedge clk_sys);
        if (cyc < 8192) wave[cyc] = tapein;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_req && !prev_req) req_rises++;
        prev_req = rd_req;
    end

    // Memory: ack after a per-address number of request cycles.
    initial begin
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk_sys);
            rd_ack = 1'b0;
            if (force_ack) begin
                rd_ack    = 1'b1;
                rd_data   = 8'h5A;
                force_ack = 1'b0;
            end else if (rd_req && mem_en) begin
                wait_cnt++;
                if (wait_cnt >= ((int'(rd_addr) == slow_addr) ? slow_delay : 3)) begin
                    rd_ack             = 1'b1;
                    rd_data            = mem[rd_addr[0]];
                    ack_edge[rd_addr[0]] = cyc + 1;
                    wait_cnt           = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Recovers one byte whose first half-bit starts at log index l.
    // Bit 8 of the result is set only when every half is uniform and
    // each pair has the form (~b, b).
    function automatic logic [8:0] decode_byte(input int l);
        logic [7:0] b;
        logic ok;
        logic a, c;
        ok = 1'b1;
        b  = '0;
        for (int i = 0; i < 8; i++) begin
            a = wave[l + 8*i];
            c = wave[l + 8*i + 4];
            for (int j = 0; j < 4; j++) begin
                if (wave[l + 8*i + j] !== a)     ok = 1'b0;
                if (wave[l + 8*i + 4 + j] !== c) ok = 1'b0;
            end
            if (a !== ~c) ok = 1'b0;
            b[7-i] = c;
        end
        return {ok, b};
    endfunction

    task automatic do_start(input logic [15:0] len);
        @(negedge clk_sys);
        busy_cnt  = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        req_rises = 0;
        length    = len;
        start     = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk_sys);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({tapein, busy, done, rd_req, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {tapein, busy, done, rd_req, underrun});
        end
        checks++;
        if (rd_addr !== 16'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d want=0", rd_addr);
        end
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_playback();
        logic [8:0] dec;
        logic [7:0] e;
        mem[0] = 8'hA5; mem[1] = 8'h3C; slow_addr = -1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE6);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        do_start(16'd2);
        checks++;
        if (busy !== 1'b1 || tapein !== 1'b1) begin
            failures++;
            $display("FAIL play_first_cycle busy=%b tapein=%b want=1,1", busy, tapein);
        end
        wait_done();
        for (int k = 0; k < 5; k++) begin
            dec = decode_byte(e0 + 64*k);
            e   = exp_q.pop_front();
            checks++;
            if (dec !== {1'b1, e}) begin
                failures++;
                $display("FAIL play_byte%0d got=%h ok=%b want=%h", k, dec[7:0], dec[8], e);
            end
        end
        checks++;
        if (busy_cnt !== 320 || done_cnt !== 1 || done_cyc !== e0 + 320) begin
            failures++;
            $display("FAIL play_timing busy=%0d done=%0d at=%0d want=320,1,%0d", busy_cnt, done_cnt, done_cyc, e0 + 320);
        end
        checks++;
        if (underrun !== 1'b0 || tapein !== 1'b0) begin
            failures++;
            $display("FAIL play_end underrun=%b tapein=%b want=0,0", underrun, tapein);
        end
    endtask

    task automatic test_zero_length();
        logic [8:0] dec;
        logic [7:0] e;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE6);
        do_start(16'd0);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            dec = decode_byte(e0 + 64*k);
            e   = exp_q.pop_front();
            checks++;
            if (dec !== {1'b1, e}) begin
                failures++;
                $display("FAIL zero_byte%0d got=%h ok=%b want=%h", k, dec[7:0], dec[8], e);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== e0 + 192 || busy_cnt !== 192) begin
            failures++;
            $display("FAIL zero_timing done=%0d at=%0d busy=%0d want=1,%0d,192", done_cnt, done_cyc, busy_cnt, e0 + 192);
        end
        checks++;
        if (req_rises !== 1) begin
            failures++;
            $display("FAIL zero_fetches got=%0d want=1", req_rises);
        end
    endtask

    task automatic test_stall();
        logic [8:0] dec;
        logic [7:0] e;
        int l [0:4];
        int held;
        slow_addr = 1; slow_delay = 100;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE6);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        do_start(16'd2);
        wait_done();
        for (int k = 0; k < 4; k++) l[k] = e0 + 64*k;
        l[4] = (ack_edge[1] + 1 > l[3] + 64) ? ack_edge[1] + 1 : l[3] + 64;
        for (int k = 0; k < 5; k++) begin
            dec = decode_byte(l[k]);
            e   = exp_q.pop_front();
            checks++;
            if (dec !== {1'b1, e}) begin
                failures++;
                $display("FAIL stall_byte%0d got=%h ok=%b want=%h", k, dec[7:0], dec[8], e);
            end
        end
        held = 1;
        for (int t = l[3] + 64; t < l[4]; t++) if (wave[t] !== 1'b1) held = 0;
        checks++;
        if (held != 1 || l[4] - (l[3] + 64) < 30) begin
            failures++;
            $display("FAIL stall_hold held=%0d gap=%0d want=1,>=30", held, l[4] - (l[3] + 64));
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== l[4] + 64 || underrun !== 1'b1) begin
            failures++;
            $display("FAIL stall_end done=%0d at=%0d underrun=%b want=1,%0d,1", done_cnt, done_cyc, underrun, l[4] + 64);
        end
        slow_addr = -1;
    endtask

    task automatic test_stop_sync();
        logic [8:0] dec;
        logic [7:0] e;
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL stop_sticky underrun=%b want=1", underrun);
        end
        do_start(16'd2);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL stop_start_clears underrun=%b want=0", underrun);
        end
        while (cyc < e0 + 158) @(negedge clk_sys);
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        checks++;
        if ({tapein, busy, rd_req} !== 3'b000) begin
            failures++;
            $display("FAIL stop_outputs tapein,busy,rd_req=%b want=000", {tapein, busy, rd_req});
        end
        repeat (10) @(negedge clk_sys);
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_done done=%0d busy=%b want=0,0", done_cnt, busy);
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE6);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        do_start(16'd2);
        wait_done();
        for (int k = 0; k < 5; k++) begin
            dec = decode_byte(e0 + 64*k);
            e   = exp_q.pop_front();
            checks++;
            if (dec !== {1'b1, e}) begin
                failures++;
                $display("FAIL replay_byte%0d got=%h ok=%b want=%h", k, dec[7:0], dec[8], e);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== e0 + 320) begin
            failures++;
            $display("FAIL replay_done count=%0d at=%0d want=1,%0d", done_cnt, done_cyc, e0 + 320);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] dec;
        logic [7:0] e;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE6);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        do_start(16'd2);
        while (cyc < e0 + 100) @(negedge clk_sys);
        start = 1'b1; @(negedge clk_sys); start = 1'b0;
        while (cyc < e0 + 250) @(negedge clk_sys);
        start = 1'b1; @(negedge clk_sys); start = 1'b0;
        wait_done();
        for (int k = 0; k < 5; k++) begin
            dec = decode_byte(e0 + 64*k);
            e   = exp_q.pop_front();
            checks++;
            if (dec !== {1'b1, e}) begin
                failures++;
                $display("FAIL busy_start_byte%0d got=%h ok=%b want=%h", k, dec[7:0], dec[8], e);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== e0 + 320 || busy_cnt !== 320) begin
            failures++;
            $display("FAIL busy_start_done count=%0d at=%0d busy=%0d want=1,%0d,320", done_cnt, done_cyc, busy_cnt, e0 + 320);
        end
        @(negedge clk_sys);
        start = 1'b1; stop = 1'b1;
        @(negedge clk_sys);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_same busy=%b rd_req=%b want=0,0", busy, rd_req);
        end
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b0 || tapein !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_after busy=%b tapein=%b want=0,0", busy, tapein);
        end
    endtask

    task automatic test_reset_data();
        slow_addr = 1; slow_delay = 1000;
        do_start(16'd2);
        while (cyc < e0 + 202) @(negedge clk_sys);
        checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre rd_req=%b busy=%b want=1,1", rd_req, busy);
        end
        mem_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        checks++;
        if ({tapein, busy, done, rd_req, underrun} !== 5'b0 || rd_addr !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid outputs=%b addr=%0d want=00000,0", {tapein, busy, done, rd_req, underrun}, rd_addr);
        end
        force_ack = 1'b1;
        repeat (4) @(negedge clk_sys);
        checks++;
        if ({tapein, busy, rd_req} !== 3'b0 || rd_addr !== 16'd0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL rst_late_ack outputs=%b addr=%0d done=%0d want=000,0,0", {tapein, busy, rd_req}, rd_addr, done_cnt);
        end
        mem_en    = 1'b1;
        slow_addr = -1;
    endtask

    initial begin
        test_reset();
        test_playback();
        test_zero_length();
        test_stall();
        test_stop_sync();
        test_back_to_back();
        test_reset_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
